// File: rtl/a_bus_arbiter.sv
// Round-robin arbiter sharing the A-bus source mux among NREQ requesters.
// Each grant runs IDLE -> SEL -> DATA, and illegal source codes are rejected with an err pulse.
module a_bus_arbiter #(
    parameter int NREQ   = 4,
    parameter int CODE_W = 5
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CODE_W-1:0]   req_code,
    input  logic [NREQ-1:0]          req_lock,
    output logic [NREQ-1:0]          gnt,
    output logic [1:0]               MUX1S,
    output logic [CODE_W-1:0]        MUX1D_out,
    output logic                     bus_valid,
    output logic                     err,
    output logic [2:0]               err_id,
    output logic                     busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, SEL, DATA} state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     win_idx;
    logic              win_found;
    logic [CODE_W-1:0] win_code;
    logic [PW-1:0]     ptr_next;

    function automatic logic code_legal(input logic [CODE_W-1:0] c);
        return ((c >= CODE_W'(1))  && (c <= CODE_W'(15))) ||
               ((c >= CODE_W'(18)) && (c <= CODE_W'(21)));
    endfunction

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
            end
        end
        win_code = req_code[int'(win_idx)*CODE_W +: CODE_W];
        ptr_next = PW'((int'(win_idx) + 1) % NREQ);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            gnt       <= '0;
            MUX1S     <= 2'd0;
            MUX1D_out <= '0;
            bus_valid <= 1'b0;
            err       <= 1'b0;
            err_id    <= 3'd0;
            busy      <= 1'b0;
        end else begin
            err    <= 1'b0;
            err_id <= 3'd0;
            case (state)
                IDLE: begin
                    bus_valid <= 1'b0;
                    if (win_found) begin
                        ptr <= ptr_next;
                        if (code_legal(win_code)) begin
                            state     <= SEL;
                            owner     <= win_idx;
                            gnt       <= NREQ'(1) << win_idx;
                            MUX1S     <= 2'd2;
                            MUX1D_out <= win_code;
                            busy      <= 1'b1;
                        end else begin
                            err    <= 1'b1;
                            err_id <= 3'(win_idx);
                        end
                    end else begin
                        MUX1S <= 2'd0;
                    end
                end
                SEL: begin
                    if (req[owner]) begin
                        state     <= DATA;
                        bus_valid <= 1'b1;
                    end else begin
                        state <= IDLE;
                        gnt   <= '0;
                        MUX1S <= 2'd0;
                        busy  <= 1'b0;
                    end
                end
                DATA: begin
                    // Locked owners keep the bus; the latched code is never re-sampled.
                    if (req[owner] && req_lock[owner]) begin
                        bus_valid <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        gnt       <= '0;
                        MUX1S     <= 2'd0;
                        bus_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
